// File: rtl/iic_read_bytes.sv
// ---------------------------------------------------------------------------
// iic_read_bytes
//
// I2C master read-data engine. Once the controller has finished the
// address/read byte, this block clocks in 1..MAX_BYTES bytes from SDA
// (MSB first). It drives ACK after every byte except the last, and NACK
// after the last. It then pulses done. SCL timing comes from the
// neighbouring SCL generator as mid-phase strobes. SDA is owned only
// through an open-drain pull-down enable.
//
// Ports
//   clk      in   system clock, rising edge active
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle transfer request, accepted only when idle
//   nbytes   in   requested byte count (0 -> 1, >MAX_BYTES -> MAX_BYTES)
//   abort    in   drop the transfer and release SDA on the next edge
//   scl      in   current SCL level (after stretching)
//   scl_hc   in   strobe at SCL-high centre (sample point)
//   scl_lc   in   strobe at SCL-low centre (SDA change point)
//   sda_in   in   synchronised SDA level
//   sda_oe   out  1 = pull SDA low (ACK), 0 = release
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse
//   rdata    out  received bytes, byte k in [8k+7:8k], byte 0 first
//   rlen     out  byte count of the last completed transfer
// ---------------------------------------------------------------------------
module iic_read_bytes #(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       nbytes,
  input  logic                   abort,
  input  logic                   scl,
  input  logic                   scl_hc,
  input  logic                   scl_lc,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic [CNT_W-1:0]       rlen
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECV     = 3'd1,
    S_ACK_SET  = 3'd2,
    S_ACK_HOLD = 3'd3,
    S_ACK_REL  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  // Map the requested count into the supported range 1..MAX_BYTES.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] c;
    if (n == {CNT_W{1'b0}}) begin
      c = CNT_W'(1);
    end else if (n > CNT_W'(MAX_BYTES)) begin
      c = CNT_W'(MAX_BYTES);
    end else begin
      c = n;
    end
    return c;
  endfunction

  state_t                   state_r, state_s;
  logic [2:0]               bitcnt_r, bitcnt_s;
  logic [CNT_W-1:0]         byte_idx_r, byte_idx_s;
  logic [CNT_W-1:0]         count_r, count_s;
  logic [7:0]               cur_byte_r, cur_byte_s;
  logic                     sda_oe_r, sda_oe_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic [8*MAX_BYTES-1:0]   rdata_r, rdata_s;
  logic [CNT_W-1:0]         rlen_r, rlen_s;

  logic                     hc_ok_s;
  logic                     lc_ok_s;
  logic                     last_byte_s;

  // Strobes only count when SCL is at the matching level. This filters
  // strobes that land while a slave is still stretching the clock. If
  // both strobes look valid together, the sample strobe wins.
  assign hc_ok_s     = scl_hc & scl;
  assign lc_ok_s     = scl_lc & ~scl & ~hc_ok_s;
  assign last_byte_s = ((byte_idx_r + CNT_W'(1)) >= count_r);

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so each output changes on the edge that sees its
  // triggering strobe.
  always_comb begin
    state_s    = state_r;
    bitcnt_s   = bitcnt_r;
    byte_idx_s = byte_idx_r;
    count_s    = count_r;
    cur_byte_s = cur_byte_r;
    sda_oe_s   = sda_oe_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    rdata_s    = rdata_r;
    rlen_s     = rlen_r;

    if (abort) begin
      // Abort keeps rlen and any partially received rdata.
      state_s  = S_IDLE;
      sda_oe_s = 1'b0;
      busy_s   = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          sda_oe_s = 1'b0;
          busy_s   = 1'b0;
          if (start) begin
            state_s    = S_RECV;
            busy_s     = 1'b1;
            bitcnt_s   = 3'd7;
            byte_idx_s = {CNT_W{1'b0}};
            count_s    = clamp_count(nbytes);
            cur_byte_s = 8'h00;
            rdata_s    = '0;
          end else begin
            state_s = S_IDLE;
          end
        end

        S_RECV: begin
          sda_oe_s = 1'b0;
          if (hc_ok_s) begin
            cur_byte_s[bitcnt_r] = sda_in;
            if (bitcnt_r == 3'd0) begin
              // The complete byte goes straight into its slot, so the
              // slot is visible one cycle after the 8th sample.
              for (int k = 0; k < MAX_BYTES; k++) begin
                rdata_s[8*k +: 8] = (byte_idx_r == CNT_W'(k)) ? cur_byte_s
                                                              : rdata_r[8*k +: 8];
              end
              state_s = S_ACK_SET;
            end else begin
              bitcnt_s = bitcnt_r - 3'd1;
            end
          end else begin
            state_s = S_RECV;
          end
        end

        S_ACK_SET: begin
          if (lc_ok_s) begin
            // ACK (pull low) while more bytes follow. NACK (release) on
            // the last byte.
            sda_oe_s = ~last_byte_s;
            state_s  = S_ACK_HOLD;
          end else begin
            state_s = S_ACK_SET;
          end
        end

        S_ACK_HOLD: begin
          if (hc_ok_s) begin
            if (last_byte_s) begin
              // done/rlen/busy take their FINISH values on this edge, so
              // the FINISH cycle itself shows done=1 and busy=0.
              state_s = S_FINISH;
              done_s  = 1'b1;
              busy_s  = 1'b0;
              rlen_s  = count_r;
            end else begin
              byte_idx_s = byte_idx_r + CNT_W'(1);
              state_s    = S_ACK_REL;
            end
          end else begin
            state_s = S_ACK_HOLD;
          end
        end

        S_ACK_REL: begin
          if (lc_ok_s) begin
            sda_oe_s   = 1'b0;
            bitcnt_s   = 3'd7;
            cur_byte_s = 8'h00;
            state_s    = S_RECV;
          end else begin
            state_s = S_ACK_REL;
          end
        end

        S_FINISH: begin
          sda_oe_s = 1'b0;
          busy_s   = 1'b0;
          state_s  = S_IDLE;
        end

        default: begin
          state_s  = S_IDLE;
          sda_oe_s = 1'b0;
          busy_s   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. The asynchronous reset releases SDA
  // without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      bitcnt_r   <= 3'd7;
      byte_idx_r <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      cur_byte_r <= 8'h00;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rdata_r    <= '0;
      rlen_r     <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      bitcnt_r   <= bitcnt_s;
      byte_idx_r <= byte_idx_s;
      count_r    <= count_s;
      cur_byte_r <= cur_byte_s;
      sda_oe_r   <= sda_oe_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      rdata_r    <= rdata_s;
      rlen_r     <= rlen_s;
    end
  end

  assign sda_oe = sda_oe_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign rdata  = rdata_r;
  assign rlen   = rlen_r;

endmodule

// File: tb/tb_iic_read_bytes.sv
// ---------------------------------------------------------------------------
// tb_iic_read_bytes
//
// Self-checking bench for iic_read_bytes with MAX_BYTES = 4. A table of
// transfers is played through a simple SCL/strobe model. Expected rdata and
// rlen are queued when each transfer starts and compared when done fires.
// Hand-written sequences cover the following cases:
//   - start ignored while busy
//   - abort in mid-byte
//   - asynchronous reset while ACK is being driven
// ---------------------------------------------------------------------------
module tb_iic_read_bytes;

  localparam int MAXB = 4;
  localparam int CW   = 3;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            start  = 1'b0;
  logic [CW-1:0]   nbytes = '0;
  logic            abort  = 1'b0;
  logic            scl    = 1'b0;
  logic            scl_hc = 1'b0;
  logic            scl_lc = 1'b0;
  logic            sda_in = 1'b1;
  logic            sda_oe;
  logic            busy;
  logic            done;
  logic [8*MAXB-1:0] rdata;
  logic [CW-1:0]   rlen;

  iic_read_bytes #(.MAX_BYTES(MAXB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .nbytes (nbytes),
    .abort  (abort),
    .scl    (scl),
    .scl_hc (scl_hc),
    .scl_lc (scl_lc),
    .sda_in (sda_in),
    .sda_oe (sda_oe),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .rlen   (rlen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] n;
    logic [31:0]   data;
    logic [31:0]   exp_rdata;
    int            exp_cnt;
    bit            bad;
  } vec_t;

  typedef struct {
    logic [31:0]   rdata;
    logic [CW-1:0] rlen;
  } exp_t;

  vec_t          vec [6];
  exp_t          sb [$];
  int            checks      = 0;
  int            errors      = 0;
  int            done_pulses = 0;
  int            exp_pulses  = 0;
  logic [CW-1:0] last_rlen   = '0;

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Low phase of one SCL period: slave puts d on SDA, low-centre strobe.
  task automatic half_low(input logic d);
    scl    = 1'b0;
    sda_in = d;
    tick();
    scl_lc = 1'b1;
    tick();
    scl_lc = 1'b0;
  endtask

  // High phase; optionally fire a bogus sample strobe while SCL is still low.
  task automatic half_high(input bit bad);
    if (bad) begin
      scl_hc = 1'b1;
      tick();
      scl_hc = 1'b0;
    end
    scl = 1'b1;
    tick();
    scl_hc = 1'b1;
    tick();
    scl_hc = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit bad);
    for (int i = 0; i < nbits; i++) begin
      half_low(b[7-i]);
      half_high(bad);
      chk("oe_during_data", {31'd0, sda_oe}, 32'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit bad);
    send_bits(b, 8, bad);
    half_low(1'b1);
    chk("ack_oe", {31'd0, sda_oe}, last ? 32'd0 : 32'd1);
    chk("busy_in_ack", {31'd0, busy}, 32'd1);
    half_high(1'b0);
  endtask

  task automatic finish_check();
    int   lat;
    exp_t e;
    lat = 0;
    while (done !== 1'b1 && lat < 4) begin
      tick();
      lat++;
    end
    chk("done_latency", 32'(lat), 32'd0);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got done with no queued transfer expected one");
    end else begin
      e = sb.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("rlen", {29'd0, rlen}, {29'd0, e.rlen});
      last_rlen = e.rlen;
    end
    chk("busy_with_done", {31'd0, busy}, 32'd0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v);
    exp_t e;
    nbytes = v.n;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    e.rdata = v.exp_rdata;
    e.rlen  = CW'(v.exp_cnt);
    sb.push_back(e);
    exp_pulses++;
    for (int k = 0; k < v.exp_cnt; k++) begin
      send_byte(v.data[8*k +: 8], (k == v.exp_cnt - 1), v.bad);
    end
    finish_check();
  endtask

  initial begin
    vec[0] = '{3'd1, 32'h000000A5, 32'h000000A5, 1, 1'b0};
    vec[1] = '{3'd3, 32'h00563412, 32'h00563412, 3, 1'b0};
    vec[2] = '{3'd0, 32'h0000003C, 32'h0000003C, 1, 1'b0};
    vec[3] = '{3'd7, 32'hEFBEADDE, 32'hEFBEADDE, 4, 1'b0};
    vec[4] = '{3'd1, 32'h000000A5, 32'h000000A5, 1, 1'b1};
    vec[5] = '{3'd2, 32'h000000FF, 32'h000000FF, 2, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rlen", {29'd0, rlen}, 32'd0);

    // Table-driven transfers
    for (int i = 0; i < 6; i++) begin
      run_xfer(vec[i]);
    end

    // Start while busy is ignored, then abort part-way through byte 1
    nbytes = 3'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    send_bits(8'h11, 4, 1'b0);
    nbytes = 3'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    send_bits(8'h11 << 4, 4, 1'b0);
    half_low(1'b1);
    chk("ignored_start_ack", {31'd0, sda_oe}, 32'd1);
    half_high(1'b0);
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    chk("partial_byte0", {24'd0, rdata[7:0]}, 32'h11);
    send_bits(8'hF0, 4, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_oe", {31'd0, sda_oe}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rlen", {29'd0, rlen}, {29'd0, last_rlen});
    chk("abort_rdata_kept", {24'd0, rdata[7:0]}, 32'h11);
    half_low(1'b0);
    half_high(1'b0);
    chk("idle_after_abort_oe", {31'd0, sda_oe}, 32'd0);
    chk("idle_after_abort_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while ACK is driven in ACK_HOLD
    nbytes = 3'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    send_bits(8'h77, 8, 1'b0);
    half_low(1'b1);
    chk("pre_reset_ack", {31'd0, sda_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {31'd0, sda_oe}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    scl   = 1'b0;
    tick();
    chk("post_reset_rlen", {29'd0, rlen}, 32'd0);
    last_rlen = '0;
    run_xfer(vec[1]);

    chk("done_pulse_count", 32'(done_pulses), 32'(exp_pulses));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
